// File: rtl/decode_sram_sequencer.sv
// Decode flow sequencer: UART load, M2, M1, then VGA display.
// Owns the single-port SRAM grant and each unit's enable strobes.
module decode_sram_sequencer #(
    parameter int ADDR_W         = 18,
    parameter int DATA_W         = 16,
    parameter int TIMEOUT_CYCLES = 50000000,
    parameter int M2_LAST_ADDR   = 76799,
    parameter int M1_LAST_ADDR   = 262143
) (
    input  logic              CLOCK_50_I,
    input  logic              resetn,
    input  logic              start_pb,
    input  logic              uart_rx_line,
    input  logic [ADDR_W-1:0] uart_addr,
    input  logic [DATA_W-1:0] uart_wdata,
    input  logic              uart_we_n,
    output logic              uart_init,
    output logic              uart_en,
    input  logic [ADDR_W-1:0] m2_addr,
    input  logic [DATA_W-1:0] m2_wdata,
    input  logic              m2_we_n,
    output logic              m2_en,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    input  logic              m1_we_n,
    output logic              m1_en,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic              vga_en,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    output logic              sram_we_n,
    output logic [2:0]        state_o,
    output logic              done
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_UART_ARM  = 3'd1,
        S_UART_WAIT = 3'd2,
        S_M2_RUN    = 3'd3,
        S_M1_RUN    = 3'd4
    } state_t;

    localparam logic [25:0]       T_LAST  = 26'(TIMEOUT_CYCLES - 1);
    localparam logic [ADDR_W-1:0] M2_LAST = ADDR_W'(M2_LAST_ADDR);
    localparam logic [ADDR_W-1:0] M1_LAST = ADDR_W'(M1_LAST_ADDR);

    state_t      state;
    logic [25:0] timer;

    assign state_o = state;

    always_ff @(posedge CLOCK_50_I or negedge resetn) begin
        if (!resetn) begin
            state     <= S_IDLE;
            timer     <= '0;
            vga_en    <= 1'b1;
            m1_en     <= 1'b0;
            m2_en     <= 1'b0;
            uart_init <= 1'b0;
            uart_en   <= 1'b0;
            done      <= 1'b0;
        end else begin
            uart_init <= 1'b0;
            uart_en   <= 1'b0;
            done      <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    timer  <= '0;
                    vga_en <= 1'b1;
                    if (!uart_rx_line || start_pb) begin
                        uart_init <= 1'b1;
                        vga_en    <= 1'b0;
                        state     <= S_UART_ARM;
                    end
                end
                S_UART_ARM: begin
                    timer   <= '0;
                    uart_en <= 1'b1;
                    state   <= S_UART_WAIT;
                end
                S_UART_WAIT: begin
                    // End of file: the line has gone quiet after real data
                    if (!uart_we_n || uart_init)
                        timer <= '0;
                    else if (timer != '1)
                        timer <= timer + 26'd1;
                    if (uart_we_n && timer == T_LAST && uart_addr != '0) begin
                        uart_init <= 1'b1;
                        m2_en     <= 1'b1;
                        state     <= S_M2_RUN;
                    end
                end
                S_M2_RUN: begin
                    timer <= '0;
                    if (!m2_we_n && m2_addr == M2_LAST) begin
                        m2_en <= 1'b0;
                        m1_en <= 1'b1;
                        state <= S_M1_RUN;
                    end
                end
                S_M1_RUN: begin
                    timer <= '0;
                    if (!m1_we_n && m1_addr == M1_LAST) begin
                        m1_en  <= 1'b0;
                        vga_en <= 1'b1;
                        done   <= 1'b1;
                        state  <= S_IDLE;
                    end
                end
                default: begin
                    timer <= '0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        sram_addr  = vga_addr;
        sram_wdata = uart_wdata;
        sram_we_n  = 1'b1;
        unique case (state)
            S_UART_ARM, S_UART_WAIT: begin
                sram_addr  = uart_addr;
                sram_wdata = uart_wdata;
                sram_we_n  = uart_we_n;
            end
            S_M2_RUN: begin
                sram_addr  = m2_addr;
                sram_wdata = m2_wdata;
                sram_we_n  = m2_we_n;
            end
            S_M1_RUN: begin
                sram_addr  = m1_addr;
                sram_wdata = m1_wdata;
                sram_we_n  = m1_we_n;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_decode_sram_sequencer.sv
// Scoreboard bench for decode_sram_sequencer.
// Expected values are queued with stimulus and popped at sample time.
module tb_decode_sram_sequencer;

    localparam int AW = 18;
    localparam int DW = 16;
    localparam logic [AW-1:0] VGA_A = 18'h30001;

    logic          CLOCK_50_I = 1'b0;
    logic          resetn;
    logic          start_pb;
    logic          uart_rx_line;
    logic [AW-1:0] uart_addr;
    logic [DW-1:0] uart_wdata;
    logic          uart_we_n;
    logic          uart_init;
    logic          uart_en;
    logic [AW-1:0] m2_addr;
    logic [DW-1:0] m2_wdata;
    logic          m2_we_n;
    logic          m2_en;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_wdata;
    logic          m1_we_n;
    logic          m1_en;
    logic [AW-1:0] vga_addr;
    logic          vga_en;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_wdata;
    logic          sram_we_n;
    logic [2:0]    state_o;
    logic          done;

    decode_sram_sequencer #(
        .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(100),
        .M2_LAST_ADDR(76799), .M1_LAST_ADDR(262143)
    ) dut (
        .CLOCK_50_I(CLOCK_50_I), .resetn(resetn),
        .start_pb(start_pb), .uart_rx_line(uart_rx_line),
        .uart_addr(uart_addr), .uart_wdata(uart_wdata),
        .uart_we_n(uart_we_n), .uart_init(uart_init),
        .uart_en(uart_en), .m2_addr(m2_addr),
        .m2_wdata(m2_wdata), .m2_we_n(m2_we_n),
        .m2_en(m2_en), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_we_n(m1_we_n),
        .m1_en(m1_en), .vga_addr(vga_addr),
        .vga_en(vga_en), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_we_n(sram_we_n),
        .state_o(state_o), .done(done)
    );

    always #10 CLOCK_50_I = ~CLOCK_50_I;

    typedef enum int {
        SG_STATE, SG_VGA, SG_M1, SG_M2, SG_INIT,
        SG_UEN, SG_DONE, SG_WE, SG_ADDR, SG_WDATA
    } sig_t;

    typedef struct {
        sig_t        s;
        logic [31:0] v;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    function automatic string nm(sig_t s);
        case (s)
            SG_STATE: return "state";
            SG_VGA:   return "vga_en";
            SG_M1:    return "m1_en";
            SG_M2:    return "m2_en";
            SG_INIT:  return "uart_init";
            SG_UEN:   return "uart_en";
            SG_DONE:  return "done";
            SG_WE:    return "sram_we_n";
            SG_ADDR:  return "sram_addr";
            default:  return "sram_wdata";
        endcase
    endfunction

    function automatic logic [31:0] obs(sig_t s);
        case (s)
            SG_STATE: return 32'(state_o);
            SG_VGA:   return 32'(vga_en);
            SG_M1:    return 32'(m1_en);
            SG_M2:    return 32'(m2_en);
            SG_INIT:  return 32'(uart_init);
            SG_UEN:   return 32'(uart_en);
            SG_DONE:  return 32'(done);
            SG_WE:    return 32'(sram_we_n);
            SG_ADDR:  return 32'(sram_addr);
            default:  return 32'(sram_wdata);
        endcase
    endfunction

    task automatic check(string tag, logic [31:0] got,
                         logic [31:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h want %0h", tag, got, want);
    endtask

    task automatic ex(sig_t s, logic [31:0] v);
        exp_t e;
        e.s = s;
        e.v = v;
        q.push_back(e);
    endtask

    task automatic sb_drain(string ctx);
        exp_t e;
        while (q.size() > 0) begin
            e = q.pop_front();
            check({ctx, ".", nm(e.s)}, obs(e.s), e.v);
        end
    endtask

    task automatic tick(int n = 1);
        repeat (n) @(posedge CLOCK_50_I);
        #1;
    endtask

    task automatic to_m1();
        uart_addr = 18'd5;
        uart_we_n = 1'b0;
        tick();
        uart_we_n = 1'b1;
        tick(100);
        m2_addr = 18'd76799;
        m2_we_n = 1'b0;
        tick();
        m2_we_n = 1'b1;
    endtask

    initial begin
        resetn       = 1'b0;
        start_pb     = 1'b0;
        uart_rx_line = 1'b1;
        uart_addr    = 18'h00010;
        uart_wdata   = 16'hA5A5;
        uart_we_n    = 1'b1;
        m2_addr      = 18'h00100;
        m2_wdata     = 16'h2222;
        m2_we_n      = 1'b1;
        m1_addr      = 18'h00200;
        m1_wdata     = 16'h1111;
        m1_we_n      = 1'b1;
        vga_addr     = VGA_A;

        #25;
        ex(SG_STATE, 0); ex(SG_VGA, 1); ex(SG_M1, 0);
        ex(SG_M2, 0); ex(SG_INIT, 0); ex(SG_DONE, 0);
        ex(SG_WE, 1); ex(SG_ADDR, 32'(VGA_A));
        sb_drain("reset");
        @(negedge CLOCK_50_I);
        resetn = 1'b1;
        tick();
        ex(SG_STATE, 0); ex(SG_VGA, 1);
        sb_drain("idle");

        start_pb = 1'b1;
        tick();
        start_pb = 1'b0;
        ex(SG_STATE, 1); ex(SG_INIT, 1); ex(SG_VGA, 0);
        ex(SG_ADDR, 32'h10);
        sb_drain("start");
        tick();
        ex(SG_STATE, 2); ex(SG_INIT, 0); ex(SG_UEN, 1);
        sb_drain("arm");
        tick();
        ex(SG_STATE, 2); ex(SG_UEN, 0);
        sb_drain("wait");

        uart_addr = '0;
        uart_we_n = 1'b0;
        #1;
        ex(SG_WE, 0); ex(SG_ADDR, 0); ex(SG_WDATA, 32'hA5A5);
        sb_drain("uwrite0");
        tick();
        uart_we_n = 1'b1;
        tick(1000);
        ex(SG_STATE, 2); ex(SG_M2, 0);
        sb_drain("addr0_hold");

        uart_addr = 18'd5;
        uart_we_n = 1'b0;
        tick();
        uart_we_n = 1'b1;
        tick(99);
        ex(SG_STATE, 2); ex(SG_M2, 0);
        sb_drain("tmo_99");
        tick();
        ex(SG_STATE, 3); ex(SG_M2, 1); ex(SG_INIT, 1);
        sb_drain("tmo_100");

        m2_addr   = 18'd76799;
        m2_wdata  = 16'h1234;
        uart_we_n = 1'b0;
        #1;
        ex(SG_ADDR, 76799); ex(SG_WDATA, 32'h1234);
        ex(SG_WE, 1);
        sb_drain("m2_mux");
        tick();
        uart_we_n = 1'b1;
        ex(SG_STATE, 3); ex(SG_INIT, 0);
        sb_drain("m2_read_last");
        m2_we_n = 1'b0;
        tick();
        m2_we_n = 1'b1;
        ex(SG_STATE, 4); ex(SG_M2, 0); ex(SG_M1, 1);
        sb_drain("m2_done");

        m1_addr = 18'd100;
        m2_we_n = 1'b0;
        #1;
        ex(SG_WE, 1); ex(SG_ADDR, 100); ex(SG_WDATA, 32'h1111);
        sb_drain("m1_stray");
        tick();
        m2_we_n = 1'b1;
        ex(SG_STATE, 4);
        sb_drain("m1_run");
        m1_addr = 18'd262143;
        m1_we_n = 1'b0;
        #1;
        ex(SG_WE, 0);
        sb_drain("m1_write");
        tick();
        m1_we_n = 1'b1;
        ex(SG_STATE, 0); ex(SG_DONE, 1); ex(SG_VGA, 1);
        ex(SG_M1, 0); ex(SG_ADDR, 32'(VGA_A));
        sb_drain("m1_done");
        tick();
        ex(SG_DONE, 0); ex(SG_STATE, 0);
        sb_drain("done_1cyc");

        uart_rx_line = 1'b0;
        start_pb     = 1'b1;
        tick();
        uart_rx_line = 1'b1;
        start_pb     = 1'b0;
        ex(SG_STATE, 1); ex(SG_INIT, 1);
        sb_drain("simul");
        tick();
        ex(SG_STATE, 2); ex(SG_INIT, 0); ex(SG_UEN, 1);
        sb_drain("simul_arm");
        tick();
        ex(SG_STATE, 2); ex(SG_UEN, 0); ex(SG_INIT, 0);
        sb_drain("simul_wait");

        to_m1();
        ex(SG_STATE, 4); ex(SG_M1, 1);
        sb_drain("rerun_m1");
        m1_addr = 18'd7;
        m1_we_n = 1'b0;
        #2;
        resetn = 1'b0;
        #1;
        ex(SG_STATE, 0); ex(SG_VGA, 1); ex(SG_M1, 0);
        ex(SG_M2, 0); ex(SG_WE, 1); ex(SG_ADDR, 32'(VGA_A));
        sb_drain("reset_mid");
        m1_we_n = 1'b1;
        @(negedge CLOCK_50_I);
        resetn = 1'b1;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
